axi_rd_arbiter: RTL and testbench

Shares the CPU's single AXI read channel (AR/R) between the instruction-cache line refill and the load unit. It arbitrates round-robin, drives one AXI read transaction at a time, and steers the returned beats to the owning requester. The icache side receives an 8-beat INCR line burst; the load side receives a single sized beat. Sits between the icache/LSU and the AXI interconnect.

---
 rtl/axi_rd_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read channel (AR/R) between the icache line
// refill and the load unit. Round-robin arbitration, one transaction in flight,
// returned beats steered combinationally to the owning requester.
module axi_rd_arbiter #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int IC_BURST_LEN   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // icache refill port
    input  logic                      ic_req_i,
    input  logic [AXI_ADDR_WIDTH-1:0] ic_addr_i,
    output logic                      ic_gnt_o,
    output logic [AXI_DATA_WIDTH-1:0] ic_rdata_o,
    output logic                      ic_rvalid_o,
    output logic                      ic_rlast_o,
    output logic                      ic_err_o,
    // load unit port
    input  logic                      ls_req_i,
    input  logic [AXI_ADDR_WIDTH-1:0] ls_addr_i,
    input  logic [1:0]                ls_size_i,
    output logic                      ls_gnt_o,
    output logic [AXI_DATA_WIDTH-1:0] ls_rdata_o,
    output logic                      ls_rvalid_o,
    output logic                      ls_err_o,
    // AXI AR channel
    output logic [AXI_ID_WIDTH-1:0]   m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    // AXI R channel
    input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam logic [2:0] AXI_SIZE_1B    = 3'b000;
    localparam logic [2:0] AXI_SIZE_2B    = 3'b001;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [7:0] IC_ARLEN       = 8'(IC_BURST_LEN - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R} state_e;
    typedef enum logic {OWN_IC, OWN_LS} owner_e;

    state_e                    r_state;
    state_e                    w_state_nxt;
    owner_e                    r_owner;
    owner_e                    r_last_owner;
    owner_e                    w_pick;
    logic                      w_any_req;
    logic                      w_ar_hs;
    logic                      w_r_hs;
    logic [3:0]                r_beat_cnt;
    logic [7:0]                w_cnt_ext;
    logic                      w_beat_err;
    logic                      w_ic_beat;
    logic                      w_ls_beat;
    logic [AXI_ID_WIDTH-1:0]   r_arid;
    logic [AXI_ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]                r_arlen;
    logic [2:0]                r_arsize;
    logic [1:0]                r_arburst;
    logic [2:0]                w_ls_arsize;
    logic                      w_unused;

    // rid is not needed for steering with a single outstanding transaction;
    // the low icache address bits are replaced by the line alignment.
    assign w_unused = ^{m_axi_rid, ic_addr_i[4:0]};

    // Round-robin pick: a lone requester wins, a tie goes to the one that
    // was not granted last.
    assign w_any_req = ic_req_i | ls_req_i;
    assign w_pick    = (ic_req_i && (!ls_req_i || r_last_owner == OWN_LS)) ? OWN_IC : OWN_LS;

    // Load size to AXI arsize; the reserved encoding 11 is treated as a word.
    always_comb begin
        unique case (ls_size_i)
            2'b00:   w_ls_arsize = AXI_SIZE_1B;
            2'b01:   w_ls_arsize = AXI_SIZE_2B;
            default: w_ls_arsize = AXI_SIZE_4B;
        endcase
    end

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is asynchronous and takes effect at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next state and channel handshake controls.
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        w_ar_hs       = 1'b0;
        w_r_hs        = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any_req) w_state_nxt = ST_AR;
            end
            ST_AR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    w_ar_hs     = 1'b1;
                    w_state_nxt = ST_R;
                end
            end
            ST_R: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    w_r_hs = 1'b1;
                    if (m_axi_rlast) w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch owner and AR fields at arbitration; they stay frozen until the
    // next arbitration so requester inputs may change freely meanwhile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner   <= OWN_IC;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
        end else if (r_state == ST_IDLE && w_any_req) begin
            r_owner   <= w_pick;
            r_arburst <= AXI_BURST_INCR;
            if (w_pick == OWN_IC) begin
                r_arid   <= '0;
                r_araddr <= {ic_addr_i[AXI_ADDR_WIDTH-1:5], 5'b0};
                r_arlen  <= IC_ARLEN;
                r_arsize <= AXI_SIZE_4B;
            end else begin
                r_arid   <= AXI_ID_WIDTH'(1);
                r_araddr <= ls_addr_i;
                r_arlen  <= 8'd0;
                r_arsize <= w_ls_arsize;
            end
        end
    end

    // Remember who was granted last; reset favours the icache on the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_last_owner <= OWN_LS;
        else if (w_ar_hs) r_last_owner <= r_owner;
    end

    // Count accepted beats; cleared on entry to R, saturating so overrun
    // beats keep reading as beyond the burst length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            r_beat_cnt <= '0;
        else if (w_ar_hs)                      r_beat_cnt <= '0;
        else if (w_r_hs && r_beat_cnt != 4'hF) r_beat_cnt <= r_beat_cnt + 4'd1;
    end

    // A beat is in error on a bad response, a premature or missing rlast, or
    // when it arrives past the announced burst length.
    assign w_cnt_ext  = {4'b0, r_beat_cnt};
    assign w_beat_err = (m_axi_rresp != AXI_RESP_OKAY)
                      | (m_axi_rlast && w_cnt_ext != r_arlen)
                      | (!m_axi_rlast && w_cnt_ext == r_arlen)
                      | (w_cnt_ext > r_arlen);

    assign w_ic_beat = w_r_hs && (r_owner == OWN_IC);
    assign w_ls_beat = w_r_hs && (r_owner == OWN_LS);

    assign m_axi_arid    = r_arid;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = r_arlen;
    assign m_axi_arsize  = r_arsize;
    assign m_axi_arburst = r_arburst;

    assign ic_gnt_o    = w_ar_hs && (r_owner == OWN_IC);
    assign ls_gnt_o    = w_ar_hs && (r_owner == OWN_LS);

    assign ic_rvalid_o = w_ic_beat;
    assign ic_rdata_o  = w_ic_beat ? m_axi_rdata : '0;
    assign ic_rlast_o  = w_ic_beat && m_axi_rlast;
    assign ic_err_o    = w_ic_beat && w_beat_err;

    assign ls_rvalid_o = w_ls_beat;
    assign ls_rdata_o  = w_ls_beat ? m_axi_rdata : '0;
    assign ls_err_o    = w_ls_beat && w_beat_err;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: directed stimulus pushes expected AR
// requests and R beats into queues; a negedge monitor pops and compares.
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ic_req_i = 1'b0;
    logic [31:0] ic_addr_i = '0;
    logic        ic_gnt_o, ic_rvalid_o, ic_rlast_o, ic_err_o;
    logic [31:0] ic_rdata_o;
    logic        ls_req_i = 1'b0;
    logic [31:0] ls_addr_i = '0;
    logic [1:0]  ls_size_i = '0;
    logic        ls_gnt_o, ls_rvalid_o, ls_err_o;
    logic [31:0] ls_rdata_o;
    logic [3:0]  m_axi_arid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [3:0]  m_axi_rid = '0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rlast = 1'b0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  id;
        bit          is_ic;
    } ar_t;

    typedef struct {
        bit          is_ic;
        logic [31:0] data;
        bit          last;
        bit          err;
    } beat_t;

    ar_t   exp_ar[$];
    beat_t exp_r[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_gnt_o(ic_gnt_o),
        .ic_rdata_o(ic_rdata_o), .ic_rvalid_o(ic_rvalid_o), .ic_rlast_o(ic_rlast_o),
        .ic_err_o(ic_err_o),
        .ls_req_i(ls_req_i), .ls_addr_i(ls_addr_i), .ls_size_i(ls_size_i),
        .ls_gnt_o(ls_gnt_o), .ls_rdata_o(ls_rdata_o), .ls_rvalid_o(ls_rvalid_o),
        .ls_err_o(ls_err_o),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_ar(input string tag, input ar_t e);
        check({tag, "_araddr"},  m_axi_araddr,  e.addr);
        check({tag, "_arlen"},   m_axi_arlen,   e.len);
        check({tag, "_arsize"},  m_axi_arsize,  e.size);
        check({tag, "_arburst"}, m_axi_arburst, e.burst);
        check({tag, "_arid"},    m_axi_arid,    e.id);
    endtask

    // Monitor: compares every AR handshake and every forwarded beat.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_axi_arvalid && m_axi_arready) begin
                if (exp_ar.size() == 0) begin
                    check("ar_unexpected", 1, 0);
                end else begin
                    ar_t e;
                    e = exp_ar.pop_front();
                    check_ar("ar_hs", e);
                    check("ic_gnt", ic_gnt_o, e.is_ic);
                    check("ls_gnt", ls_gnt_o, !e.is_ic);
                end
            end else if (ic_gnt_o || ls_gnt_o) begin
                check("gnt_without_handshake", {ic_gnt_o, ls_gnt_o}, 0);
            end
            if (ic_rvalid_o || ls_rvalid_o) begin
                if (ic_rvalid_o && ls_rvalid_o) check("rvalid_overlap", 1, 0);
                if (exp_r.size() == 0) begin
                    check("beat_unexpected", 1, 0);
                end else begin
                    beat_t b;
                    b = exp_r.pop_front();
                    check("beat_owner_ic", ic_rvalid_o, b.is_ic);
                    check("beat_data", b.is_ic ? ic_rdata_o : ls_rdata_o, b.data);
                    check("beat_last", ic_rlast_o, b.last);
                    check("beat_err", b.is_ic ? ic_err_o : ls_err_o, b.err);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] out_bundle();
        return {6'b0, m_axi_arvalid, m_axi_rready, ic_gnt_o, ls_gnt_o, ic_rvalid_o,
                ls_rvalid_o, ic_rlast_o, ic_err_o, ls_err_o, m_axi_araddr, m_axi_arlen,
                m_axi_arsize, m_axi_arburst, m_axi_arid};
    endfunction

    // Slave AR side: wait for arvalid, stall `delay` cycles checking the
    // fields hold, then accept for one cycle.
    task automatic ar_accept(input int delay, input ar_t e);
        for (int i = 0; i < 20 && !m_axi_arvalid; i++) cyc();
        if (!m_axi_arvalid) begin
            check("ar_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < delay; i++) begin
            check_ar("ar_hold", e);
            check("ar_hold_nognt", {ic_gnt_o, ls_gnt_o}, 0);
            cyc();
        end
        m_axi_arready = 1'b1;
        cyc();
        m_axi_arready = 1'b0;
    endtask

    // Slave R side: present one beat for one cycle and push its expectation.
    task automatic r_beat(input bit is_ic, input logic [31:0] data, input logic [1:0] resp,
                          input bit last, input bit exp_err);
        beat_t b;
        b.is_ic = is_ic;
        b.data  = data;
        b.last  = is_ic && last;
        b.err   = exp_err;
        exp_r.push_back(b);
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = data;
        m_axi_rresp  = resp;
        m_axi_rlast  = last;
        cyc();
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
    endtask

    // Icache burst of n beats; err_beat gets SLVERR, early_last ends the burst.
    task automatic ic_burst(input int n, input int err_beat, input int early_last);
        for (int b = 1; b <= n; b++) begin
            bit last;
            bit err;
            last = (b == early_last) || (early_last == 0 && b == 8);
            err  = (b == err_beat) || (b == early_last && early_last != 8);
            r_beat(1'b1, 32'hC000_0000 + 32'(b), (b == err_beat) ? 2'b10 : 2'b00, last, err);
        end
    endtask

    function automatic ar_t mk_ar(input logic [31:0] a, input logic [7:0] l,
                                  input logic [2:0] s, input logic [3:0] id, input bit ic);
        ar_t e;
        e.addr = a; e.len = l; e.size = s; e.burst = 2'b01; e.id = id; e.is_ic = ic;
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ar_t e;
        #2;
        check("reset_outputs", out_bundle(), 0);
        check("reset_rdata", {ic_rdata_o, ls_rdata_o}, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Icache only, immediate arready, clean 8-beat burst.
        ic_req_i = 1'b1; ic_addr_i = 32'h0000_1234;
        e = mk_ar(32'h0000_1220, 8'd7, 3'b010, 4'd0, 1'b1);
        exp_ar.push_back(e);
        ar_accept(0, e);
        ic_req_i = 1'b0;
        check("ic_rready_in_r", m_axi_rready, 1);
        ic_burst(8, 0, 0);
        check("ic_back_to_idle", {m_axi_arvalid, m_axi_rready}, 0);

        // Load halfword with arready stalled 3 cycles; inputs change after arbitration.
        ls_req_i = 1'b1; ls_addr_i = 32'h0000_2002; ls_size_i = 2'b01;
        cyc();
        ls_addr_i = 32'hDEAD_BEEF; ls_size_i = 2'b00;
        e = mk_ar(32'h0000_2002, 8'd0, 3'b001, 4'd1, 1'b0);
        exp_ar.push_back(e);
        ar_accept(3, e);
        ls_req_i = 1'b0;
        r_beat(1'b0, 32'h1234_ABCD, 2'b00, 1'b1, 1'b0);

        // Load with reserved size 11 (treated as word) and a DECERR response.
        ls_req_i = 1'b1; ls_addr_i = 32'h0000_5003; ls_size_i = 2'b11;
        e = mk_ar(32'h0000_5003, 8'd0, 3'b010, 4'd1, 1'b0);
        exp_ar.push_back(e);
        ar_accept(0, e);
        ls_req_i = 1'b0;
        r_beat(1'b0, 32'h5555_AAAA, 2'b11, 1'b1, 1'b1);

        // Icache with SLVERR on beat 3, then icache with early rlast on beat 5.
        ic_req_i = 1'b1; ic_addr_i = 32'h0000_8040;
        e = mk_ar(32'h0000_8040, 8'd7, 3'b010, 4'd0, 1'b1);
        exp_ar.push_back(e);
        ar_accept(0, e);
        ic_req_i = 1'b0;
        ic_burst(8, 3, 0);
        ic_req_i = 1'b1; ic_addr_i = 32'h0000_905F;
        e = mk_ar(32'h0000_9040, 8'd7, 3'b010, 4'd0, 1'b1);
        exp_ar.push_back(e);
        ar_accept(0, e);
        ic_req_i = 1'b0;
        ic_burst(5, 0, 5);
        check("early_last_idle", {m_axi_arvalid, m_axi_rready}, 0);

        // R beats presented with no transaction open must be ignored.
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'hBAD0_BAD0; m_axi_rlast = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stray_beat_blocked", {m_axi_rready, ic_rvalid_o, ls_rvalid_o}, 0);
            cyc();
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;

        // Both request continuously from reset: IC, LS, IC, LS with one idle gap.
        do_reset();
        ic_req_i = 1'b1; ic_addr_i = 32'h0000_3FFC;
        ls_req_i = 1'b1; ls_addr_i = 32'h0000_4001; ls_size_i = 2'b00;
        for (int t = 0; t < 4; t++) begin
            bit is_ic;
            is_ic = (t % 2 == 0);
            e = is_ic ? mk_ar(32'h0000_3FE0, 8'd7, 3'b010, 4'd0, 1'b1)
                      : mk_ar(32'h0000_4001, 8'd0, 3'b000, 4'd1, 1'b0);
            exp_ar.push_back(e);
            if (t > 0) begin
                check("rr_idle_gap", m_axi_arvalid, 0);
                cyc();
                check("rr_next_arvalid", m_axi_arvalid, 1);
            end
            ar_accept(0, e);
            if (is_ic) ic_burst(8, 0, 0);
            else       r_beat(1'b0, 32'h0000_00A0 + 32'(t), 2'b00, 1'b1, 1'b0);
        end
        ic_req_i = 1'b0; ls_req_i = 1'b0;
        cyc();

        // Reset during beat 4 of an icache burst, then restart.
        ic_req_i = 1'b1; ic_addr_i = 32'h0000_A000;
        e = mk_ar(32'h0000_A000, 8'd7, 3'b010, 4'd0, 1'b1);
        exp_ar.push_back(e);
        ar_accept(0, e);
        ic_req_i = 1'b0;
        ic_burst(3, 0, 0);
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'hC000_0004;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", out_bundle(), 0);
        check("mid_reset_rdata", ic_rdata_o, 0);
        m_axi_rvalid = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        ic_req_i = 1'b1; ic_addr_i = 32'h0000_B010;
        check("restart_arvalid_low", m_axi_arvalid, 0);
        cyc();
        check("restart_arvalid_high", m_axi_arvalid, 1);
        e = mk_ar(32'h0000_B000, 8'd7, 3'b010, 4'd0, 1'b1);
        exp_ar.push_back(e);
        ar_accept(0, e);
        ic_req_i = 1'b0;
        ic_burst(8, 0, 0);
        cyc();

        check("ar_queue_drained", exp_ar.size(), 0);
        check("r_queue_drained", exp_r.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
